merger_3x1: RTL and testbench

MERGER_3X1 -- requirements
Module: merger_3x1

---
 rtl/merger_pkg.sv | 14 +
 rtl/merger_fifo.sv | 53 +++++
 rtl/merger_3x1.sv | 94 +++++++++
 tb/tb_merger_3x1.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/merger_pkg.sv
// Shared port IDs and round-robin helper for the 3:1 merger.
package merger_pkg;
  localparam int NUM_PORTS = 3;

  typedef logic [1:0] port_id_t;

  localparam port_id_t PORT0 = 2'd0;
  localparam port_id_t PORT1 = 2'd1;
  localparam port_id_t PORT2 = 2'd2;

  function automatic port_id_t next_port(input port_id_t p);
    return (p == PORT2) ? PORT0 : port_id_t'(p + 2'd1);
  endfunction
endpackage

// File: rtl/merger_fifo.sv
// Per-port input buffer: FIFO_DEPTH entries, first word visible on pop_dat.
// Latency: a push is visible one edge later; push and pop may share an edge.
// Backpressure: full is driven from the count only, and a push while full is dropped.
module merger_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_dat,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign pop_dat = mem[rd_ptr];

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

// File: rtl/merger_3x1.sv
// Round-robin 3:1 merger with per-port FIFOs; 1-cycle latency from accept to output.
// Backpressure: output holds while valid_out && !ready_in; ready_out[i] = !full. Optional MERGER_PARITY_EN adds parity_out.
module merger_3x1
  import merger_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in [NUM_PORTS],
  input  logic [2:0]        valid_in,
  output logic [2:0]        ready_out,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        addr_out,
  output logic              valid_out,
  input  logic              ready_in
`ifdef MERGER_PARITY_EN
  ,
  output logic              parity_out
`endif
);
  logic [DATA_W-1:0]    fifo_dat [NUM_PORTS];
  logic [NUM_PORTS-1:0] fifo_full;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] fifo_pop;
  port_id_t             last_grant;
  port_id_t             gnt;
  port_id_t             cand;
  logic                 gnt_vld;
  logic                 load;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_fifo
    merger_fifo #(
      .DATA_W    (DATA_W),
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (valid_in[i] && ready_out[i]),
      .push_dat(data_in[i]),
      .pop     (fifo_pop[i]),
      .pop_dat (fifo_dat[i]),
      .full    (fifo_full[i]),
      .empty   (fifo_empty[i])
    );
  end

  assign ready_out = ~fifo_full;

  // Walk last_grant+1, +2, +3 (== last_grant) and take the first non-empty port.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = last_grant;
    cand    = last_grant;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = next_port(cand);
      if (!gnt_vld && !fifo_empty[cand]) begin
        gnt_vld = 1'b1;
        gnt     = cand;
      end
    end
  end

  assign load = gnt_vld && (!valid_out || ready_in);

  always_comb begin
    fifo_pop = '0;
    if (load) fifo_pop[gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out  <= 1'b0;
      data_out   <= '0;
      addr_out   <= '0;
      last_grant <= PORT2;
    end else if (load) begin
      valid_out  <= 1'b1;
      data_out   <= fifo_dat[gnt];
      addr_out   <= gnt;
      last_grant <= gnt;
    end else if (ready_in) begin
      valid_out  <= 1'b0;
    end
  end

`ifdef MERGER_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      parity_out <= 1'b0;
    else if (load) parity_out <= ^fifo_dat[gnt];
  end
`endif
endmodule

// File: tb/tb_merger_3x1.sv
// Directed bench for merger_3x1; parity scenario is built only with MERGER_PARITY_EN.
module tb_merger_3x1;
  logic       clk;
  logic       rst;
  logic [7:0] data_in [3];
  logic [2:0] valid_in;
  logic [2:0] ready_out;
  logic [7:0] data_out;
  logic [1:0] addr_out;
  logic       valid_out;
  logic       ready_in;
`ifdef MERGER_PARITY_EN
  logic       parity_out;
`endif

  int checks = 0;
  int errors = 0;

  merger_3x1 #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .data_out (data_out),
    .addr_out (addr_out),
    .valid_out(valid_out),
    .ready_in (ready_in)
`ifdef MERGER_PARITY_EN
    ,
    .parity_out(parity_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    valid_in = 3'b000;
    ready_in = 1'b1;
    for (int i = 0; i < 3; i++) data_in[i] = 8'h00;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    valid_in = 3'b000;
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) data_in[i] = 8'h00;
    #2;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", valid_out); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h exp 00", data_out); end
    checks++; if (addr_out !== 2'b00) begin errors++; $display("FAIL reset_addr: got %b exp 00", addr_out); end
    checks++; if (ready_out !== 3'b111) begin errors++; $display("FAIL reset_ready: got %b exp 111", ready_out); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [7:0] vals [3];
    vals = '{8'hAA, 8'hBB, 8'hCC};
    ready_in = 1'b1;
    for (int p = 0; p < 3; p++) begin
      data_in[p] = vals[p];
      valid_in   = 3'(1 << p);
      tick();
      valid_in = 3'b000;
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL single_pre_valid p%0d: got %b exp 0", p, valid_out); end
      tick();
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL single_valid p%0d: got %b exp 1", p, valid_out); end
      checks++; if (data_out !== vals[p]) begin errors++; $display("FAIL single_data p%0d: got %h exp %h", p, data_out, vals[p]); end
      checks++; if (addr_out !== 2'(p)) begin errors++; $display("FAIL single_addr p%0d: got %b exp %b", p, addr_out, 2'(p)); end
    end
    tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL single_drain_valid: got %b exp 0", valid_out); end
  endtask

  task automatic test_contention();
    logic [7:0] vals [3];
    vals = '{8'h11, 8'h22, 8'h33};
    do_reset();
    for (int p = 0; p < 3; p++) data_in[p] = vals[p];
    valid_in = 3'b111;
    tick();
    valid_in = 3'b000;
    for (int p = 0; p < 3; p++) begin
      tick();
      checks++; if (valid_out !== 1'b1 || data_out !== vals[p] || addr_out !== 2'(p)) begin
        errors++; $display("FAIL contention_word%0d: got v=%b d=%h a=%b exp v=1 d=%h a=%b",
                           p, valid_out, data_out, addr_out, vals[p], 2'(p));
      end
    end
    tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL contention_idle: got %b exp 0", valid_out); end
  endtask

  // Port 0 first parks 0F in the stalled output register, so port 1's four words all stay in FIFO 1.
  task automatic test_backpressure();
    do_reset();
    ready_in   = 1'b0;
    data_in[0] = 8'h0F;
    valid_in   = 3'b001;
    tick();
    valid_in = 3'b000;
    tick();
    checks++; if (valid_out !== 1'b1 || data_out !== 8'h0F) begin errors++; $display("FAIL bp_park: got v=%b d=%h exp v=1 d=0f", valid_out, data_out); end
    for (int k = 0; k < 4; k++) begin
      data_in[1] = 8'hA1 + 8'(k);
      valid_in   = 3'b010;
      tick();
      checks++; if (ready_out[1] !== (k == 3 ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL bp_ready_after_word%0d: got %b exp %b", k + 1, ready_out[1], (k == 3 ? 1'b0 : 1'b1));
      end
      checks++; if (valid_out !== 1'b1 || data_out !== 8'h0F || addr_out !== 2'b00) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b d=%h a=%b exp v=1 d=0f a=00", k, valid_out, data_out, addr_out);
      end
    end
    data_in[1] = 8'hA5;
    tick();
    valid_in = 3'b000;
    checks++; if (ready_out[1] !== 1'b0) begin errors++; $display("FAIL bp_fifth_blocked: got %b exp 0", ready_out[1]); end
    ready_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (valid_out !== 1'b1 || data_out !== 8'hA1 + 8'(k) || addr_out !== 2'b01) begin
        errors++; $display("FAIL bp_drain%0d: got v=%b d=%h a=%b exp v=1 d=%h a=01", k, valid_out, data_out, addr_out, 8'hA1 + 8'(k));
      end
    end
    checks++; if (ready_out !== 3'b111) begin errors++; $display("FAIL bp_ready_restored: got %b exp 111", ready_out); end
    tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL bp_no_fifth: got v=%b d=%h exp v=0", valid_out, data_out); end
  endtask

  task automatic test_fairness();
    int cnt [3];
    cnt = '{0, 0, 0};
    do_reset();
    ready_in = 1'b1;
    for (int p = 0; p < 3; p++) data_in[p] = 8'h40 + 8'(p);
    valid_in = 3'b111;
    tick();
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++; if (valid_out !== 1'b1 || addr_out !== 2'(i % 3)) begin
        errors++; $display("FAIL fair_cycle%0d: got v=%b a=%b exp v=1 a=%b", i, valid_out, addr_out, 2'(i % 3));
      end
      if (valid_out === 1'b1 && addr_out < 2'd3) cnt[addr_out]++;
    end
    valid_in = 3'b000;
    for (int p = 0; p < 3; p++) begin
      checks++; if (cnt[p] != 10) begin errors++; $display("FAIL fair_count p%0d: got %0d exp 10", p, cnt[p]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready_in = 1'b0;
    data_in  = '{8'h11, 8'h22, 8'h33};
    valid_in = 3'b111;
    tick();
    valid_in = 3'b000;
    tick();
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b exp 1", valid_out); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (valid_out !== 1'b0 || ready_out !== 3'b111) begin
      errors++; $display("FAIL rstmid_async: got v=%b r=%b exp v=0 r=111", valid_out, ready_out);
    end
    checks++; if (data_out !== 8'h00 || addr_out !== 2'b00) begin
      errors++; $display("FAIL rstmid_regs: got d=%h a=%b exp d=00 a=00", data_out, addr_out);
    end
    tick();
    rst      = 1'b1;
    ready_in = 1'b1;
    tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rstmid_flushed: got %b exp 0", valid_out); end
    data_in[2] = 8'h5A;
    valid_in   = 3'b100;
    tick();
    valid_in = 3'b000;
    tick();
    checks++; if (valid_out !== 1'b1 || data_out !== 8'h5A || addr_out !== 2'b10) begin
      errors++; $display("FAIL rstmid_first: got v=%b d=%h a=%b exp v=1 d=5a a=10", valid_out, data_out, addr_out);
    end
  endtask

`ifdef MERGER_PARITY_EN
  task automatic test_parity();
    do_reset();
    checks++; if (parity_out !== 1'b0) begin errors++; $display("FAIL parity_reset: got %b exp 0", parity_out); end
    data_in[0] = 8'h07;
    valid_in   = 3'b001;
    tick();
    data_in[0] = 8'h03;
    tick();
    valid_in = 3'b000;
    checks++; if (data_out !== 8'h07 || parity_out !== 1'b1) begin errors++; $display("FAIL parity_07: got d=%h p=%b exp d=07 p=1", data_out, parity_out); end
    tick();
    checks++; if (data_out !== 8'h03 || parity_out !== 1'b0) begin errors++; $display("FAIL parity_03: got d=%h p=%b exp d=03 p=0", data_out, parity_out); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_fairness();
    test_reset_mid();
`ifdef MERGER_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
